// File: rtl/lsu_mem_master.sv
// rtl/lsu_mem_master.sv - RISC-V load/store initiator for a word-wide, word-writable data memory
// Define LSU_SUBWORD_EN to build B/H/BU/HU lane handling and the sub-word read-modify-write path.
module lsu_mem_master #(
  parameter int MEM_SIZE = 1024,
  parameter int WORD     = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [2:0]      req_funct3,
  input  logic [31:0]     req_addr,
  input  logic [WORD-1:0] req_wdata,
  output logic            resp_valid,
  output logic [WORD-1:0] resp_rdata,
  output logic            resp_err,
  output logic            mem_we,
  output logic [31:0]     mem_address,
  output logic [WORD-1:0] mem_w_data,
  input  logic [WORD-1:0] mem_r_data
);

`ifdef LSU_SUBWORD_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LD     = 3'd1,
    ST     = 3'd2,
    RMW_RD = 3'd3,
    RMW_WR = 3'd4,
    ERR    = 3'd5,
    RESP   = 3'd6
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
`else
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LD   = 3'd1,
    ST   = 3'd2,
    ERR  = 3'd5,
    RESP = 3'd6
  } state_t;
`endif

  localparam logic [2:0]  F3_W       = 3'b010;
  localparam logic [31:0] ADDR_LIMIT = 32'(MEM_SIZE * 4);

  state_t          state_q, state_d;
  logic [31:2]     waddr_q, waddr_d;
  logic [WORD-1:0] wdata_q, wdata_d;
  logic [WORD-1:0] rdata_q, rdata_d;
  logic            err_q, err_d;
  logic            illegal;
  logic [WORD-1:0] load_val;

`ifdef LSU_SUBWORD_EN
  logic [1:0]      lane_q, lane_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [WORD-1:0] merged_q, merged_d;
  logic [WORD-1:0] merge_word;
  logic [7:0]      byte_sel;
  logic [15:0]     half_sel;
`endif

  // Legality is decided from the live request so the accept cycle already knows the path.
  always_comb begin
    illegal = (req_addr >= ADDR_LIMIT);
`ifdef LSU_SUBWORD_EN
    case (req_funct3)
      F3_B:    illegal = illegal;
      F3_BU:   illegal = illegal | req_we;
      F3_H:    illegal = illegal | req_addr[0];
      F3_HU:   illegal = illegal | req_we | req_addr[0];
      F3_W:    illegal = illegal | (req_addr[1:0] != 2'b00);
      default: illegal = 1'b1;
    endcase
`else
    if ((req_funct3 != F3_W) || (req_addr[1:0] != 2'b00)) begin
      illegal = 1'b1;
    end
`endif
  end

`ifdef LSU_SUBWORD_EN
  // Lane extraction for loads and lane replacement for the RMW merge.
  always_comb begin
    byte_sel   = mem_r_data[{lane_q, 3'b000} +: 8];
    half_sel   = mem_r_data[{lane_q[1], 4'b0000} +: 16];
    merge_word = mem_r_data;
    if (funct3_q[0]) begin
      merge_word[{lane_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    end else begin
      merge_word[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
    end
    case (funct3_q)
      F3_B:    load_val = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    load_val = {{16{half_sel[15]}}, half_sel};
      F3_BU:   load_val = {24'h000000, byte_sel};
      F3_HU:   load_val = {16'h0000, half_sel};
      default: load_val = mem_r_data;
    endcase
  end
`else
  assign load_val = mem_r_data;
`endif

  always_comb begin
    state_d     = state_q;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
`ifdef LSU_SUBWORD_EN
    lane_d      = lane_q;
    funct3_d    = funct3_q;
    merged_d    = merged_q;
`endif
    req_ready   = (state_q == IDLE);
    resp_valid  = 1'b0;
    mem_we      = 1'b0;
    mem_address = 32'h0;
    mem_w_data  = '0;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          waddr_d = req_addr[31:2];
          wdata_d = req_wdata;
          rdata_d = '0;
          err_d   = 1'b0;
`ifdef LSU_SUBWORD_EN
          lane_d   = req_addr[1:0];
          funct3_d = req_funct3;
`endif
          if (illegal) begin
            state_d = ERR;
          end else if (!req_we) begin
            state_d = LD;
`ifdef LSU_SUBWORD_EN
          end else if (req_funct3 != F3_W) begin
            state_d = RMW_RD;
`endif
          end else begin
            state_d = ST;
          end
        end
      end
      LD: begin
        mem_address = {waddr_q, 2'b00};
        rdata_d     = load_val;
        state_d     = RESP;
      end
      ST: begin
        mem_we      = 1'b1;
        mem_address = {waddr_q, 2'b00};
        mem_w_data  = wdata_q;
        state_d     = RESP;
      end
`ifdef LSU_SUBWORD_EN
      RMW_RD: begin
        mem_address = {waddr_q, 2'b00};
        merged_d    = merge_word;
        state_d     = RMW_WR;
      end
      RMW_WR: begin
        mem_we      = 1'b1;
        mem_address = {waddr_q, 2'b00};
        mem_w_data  = merged_q;
        state_d     = RESP;
      end
`endif
      ERR: begin
        err_d   = 1'b1;
        state_d = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

  // A write issued in the reset cycle still lands: mem_we is combinational from the current state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      waddr_q  <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
`ifdef LSU_SUBWORD_EN
      lane_q   <= 2'b00;
      funct3_q <= 3'b000;
      merged_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
`ifdef LSU_SUBWORD_EN
      lane_q   <= lane_d;
      funct3_q <= funct3_d;
      merged_q <= merged_d;
`endif
    end
  end

endmodule
